// File: rtl/bf_pkg.sv
// Types shared between the BF interpreter core and its bus back-end.
package bf_pkg;

    typedef enum logic [2:0] {
        BusNone      = 3'd0,
        BusReadProg  = 3'd1,
        BusReadData  = 3'd2,
        BusWriteData = 3'd3,
        BusReadIo    = 3'd4,
        BusWriteIo   = 3'd5
    } BusOp;

    // Which source feeds core_val_in after a committed request.
    typedef enum logic [1:0] {
        RsrcNone = 2'd0,
        RsrcMem  = 2'd1,
        RsrcIo   = 2'd2
    } rsrc_t;

    localparam logic RegionProg = 1'b0;
    localparam logic RegionData = 1'b1;

endpackage

// File: rtl/bf_byte_fifo.sv
// Small byte FIFO for the output channel; pushes while full and pops while
// empty are ignored, and a pop never makes room for a same-cycle push.
module bf_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through head when non-empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bf_bus_unit.sv
// Bus back-end for the BF core: serves RAM, byte-input and byte-output
// requests and stalls the core through core_enable when one cannot finish.
module bf_bus_unit
    import bf_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int BUS_WIDTH  = 8,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  BusOp                  core_bus_op,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [BUS_WIDTH-1:0]  core_val_out,
    output logic [BUS_WIDTH-1:0]  core_val_in,
    output logic                  core_enable,
    input  logic                  core_halted,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  idle
);

    rsrc_t      rsrc;
    logic [7:0] io_byte;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       in_xfer;

    // Both byte channels use valid/ready: a byte moves in exactly the cycles
    // where valid and ready are both high at the clock edge; the sender holds
    // data stable while valid is high and ready is low.
    assign core_enable = run
                       & ~((core_bus_op == BusReadIo)  & ~in_valid)
                       & ~((core_bus_op == BusWriteIo) & fifo_full);
    assign in_ready    = run & (core_bus_op == BusReadIo);
    assign in_xfer     = in_valid & in_ready;
    assign fifo_push   = core_enable & (core_bus_op == BusWriteIo);
    assign fifo_pop    = out_valid & out_ready;
    assign out_valid   = ~fifo_empty;
    assign idle        = core_halted & fifo_empty;
    assign mem_wdata   = core_val_out;

    always_comb begin
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {RegionData, core_addr};
        case (core_bus_op)
            BusReadProg: begin
                mem_re   = core_enable & ~reset;
                mem_addr = {RegionProg, core_addr};
            end
            BusReadData:  mem_re = core_enable & ~reset;
            BusWriteData: mem_we = core_enable & ~reset;
            default: ;
        endcase
    end

    // rsrc only moves on commit so a stalled core keeps seeing the same data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsrc    <= RsrcNone;
            io_byte <= 8'h00;
        end else begin
            if (core_enable) begin
                case (core_bus_op)
                    BusReadProg, BusReadData: rsrc <= RsrcMem;
                    BusReadIo:                rsrc <= RsrcIo;
                    default:                  rsrc <= RsrcNone;
                endcase
            end
            if (in_xfer) io_byte <= in_data;
        end
    end

    always_comb begin
        core_val_in = '0;
        case (rsrc)
            RsrcMem: core_val_in = mem_rdata;
            RsrcIo:  core_val_in = BUS_WIDTH'(io_byte);
            default: core_val_in = '0;
        endcase
    end

    bf_byte_fifo #(
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (core_val_out[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

endmodule

// File: tb/tb_bf_bus_unit.sv
// Directed and random checks of bf_bus_unit against a queue/array reference model.
module tb_bf_bus_unit;
    import bf_pkg::*;

    localparam int ADDR_WIDTH = 15;
    localparam int BUS_WIDTH  = 8;
    localparam int OUT_DEPTH  = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  run;
    BusOp                  core_bus_op;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [BUS_WIDTH-1:0]  core_val_out;
    logic [BUS_WIDTH-1:0]  core_val_in;
    logic                  core_enable;
    logic                  core_halted;
    logic [ADDR_WIDTH:0]   mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [BUS_WIDTH-1:0]  mem_wdata;
    logic [BUS_WIDTH-1:0]  mem_rdata;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  idle;

    bf_bus_unit #(
        .ADDR_WIDTH(ADDR_WIDTH), .BUS_WIDTH(BUS_WIDTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .core_bus_op(core_bus_op),
        .core_addr(core_addr), .core_val_out(core_val_out), .core_val_in(core_val_in),
        .core_enable(core_enable), .core_halted(core_halted), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .idle(idle)
    );

    always #5 clock = ~clock;

    // Environment RAM: 1-cycle read latency, data held while mem_re is low.
    logic [BUS_WIDTH-1:0] env_ram [0:65535];
    always @(posedge clock) begin
        if (mem_we) env_ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= env_ram[mem_addr];
    end

    int          n_writes = 0;
    int          n_xfers  = 0;
    logic [15:0] last_waddr = '0;
    always @(posedge clock) begin
        if (mem_we) begin
            n_writes++;
            last_waddr = mem_addr;
        end
        if (in_valid && in_ready) n_xfers++;
    end

    // Reference model state.
    logic [BUS_WIDTH-1:0] model_ram [0:65535];
    logic [7:0]           exp_q[$];
    logic [BUS_WIDTH-1:0] exp_val;
    logic                 exp_en;
    logic [15:0]          exp_addr;
    int                   n_checks = 0;
    int                   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; outputs checked 1 time unit later,
    // model advanced at the rising edge.
    task automatic step();
        logic is_rd;
        if (reset) begin
            exp_q.delete();
            exp_val = '0;
        end
        #1;
        exp_en = run && !(core_bus_op == BusReadIo && !in_valid)
                     && !(core_bus_op == BusWriteIo && exp_q.size() == OUT_DEPTH);
        is_rd    = (core_bus_op == BusReadProg) || (core_bus_op == BusReadData);
        exp_addr = {(core_bus_op == BusReadProg) ? 1'b0 : 1'b1, core_addr};
        check("core_enable", core_enable, exp_en);
        check("mem_re", mem_re, exp_en && is_rd && !reset);
        check("mem_we", mem_we, exp_en && core_bus_op == BusWriteData && !reset);
        if (exp_en && (is_rd || core_bus_op == BusWriteData)) check("mem_addr", mem_addr, exp_addr);
        if (exp_en && core_bus_op == BusWriteData) check("mem_wdata", mem_wdata, core_val_out);
        check("in_ready", in_ready, run && core_bus_op == BusReadIo);
        check("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        check("core_val_in", core_val_in, exp_val);
        check("idle", idle, core_halted && exp_q.size() == 0);
        @(posedge clock);
        if (!reset) begin
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (exp_en) begin
                exp_val = '0;
                case (core_bus_op)
                    BusReadProg, BusReadData: exp_val = model_ram[exp_addr];
                    BusReadIo:    exp_val = BUS_WIDTH'(in_data);
                    BusWriteData: model_ram[exp_addr] = core_val_out;
                    BusWriteIo:   exp_q.push_back(core_val_out[7:0]);
                    default: ;
                endcase
            end
        end
        @(negedge clock);
    endtask

    task automatic drive(input BusOp op, input logic [ADDR_WIDTH-1:0] a, input logic [7:0] v);
        core_bus_op  = op;
        core_addr    = a;
        core_val_out = v;
    endtask

    initial begin
        int w0;
        int x0;
        reset = 1'b1; run = 1'b0; core_halted = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        drive(BusNone, '0, 8'h00);
        for (int i = 0; i < 32; i++) begin
            env_ram[i]           = 8'($urandom);
            env_ram[16'h8000 + i] = 8'($urandom);
        end
        env_ram[5] = 8'h2B;
        for (int i = 0; i < 32; i++) begin
            model_ram[i]           = env_ram[i];
            model_ram[16'h8000 + i] = env_ram[16'h8000 + i];
        end

        // Reset values.
        @(negedge clock);
        #1;
        check("reset_out_data", out_data, 8'h00);
        check("reset_val_in", core_val_in, 8'h00);
        step();
        step();
        reset = 1'b0;
        run   = 1'b1;

        // Program read.
        drive(BusReadProg, 15'h0005, 8'h00);
        step();
        drive(BusNone, '0, 8'h00);
        #1;
        check("prog_read_data", core_val_in, 8'h2B);
        step();
        check("val_after_none", core_val_in, 8'h00);

        // IO read stall.
        x0 = n_xfers;
        drive(BusReadIo, '0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("io_stall_enable", core_enable, 1'b0);
            step();
        end
        in_valid = 1'b1;
        in_data  = 8'h41;
        step();
        in_valid = 1'b0;
        drive(BusNone, '0, 8'h00);
        #1;
        check("io_read_data", core_val_in, 8'h41);
        check("io_one_xfer", n_xfers - x0, 1);
        step();

        // Output FIFO full and no pass-through.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(BusWriteIo, '0, 8'(8'h10 + i));
            step();
        end
        drive(BusWriteIo, '0, 8'h14);
        step();
        out_ready = 1'b1;
        #1;
        check("full_pop_stall", core_enable, 1'b0);
        step();
        out_ready = 1'b0;
        step();
        drive(BusNone, '0, 8'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("drain_empty", exp_q.size(), 0);

        // Run gating of a data write.
        w0 = n_writes;
        run = 1'b0;
        drive(BusWriteData, 15'h0003, 8'h7F);
        for (int i = 0; i < 5; i++) step();
        check("gated_no_write", n_writes - w0, 0);
        run = 1'b1;
        step();
        drive(BusNone, '0, 8'h00);
        step();
        check("one_write", n_writes - w0, 1);
        check("write_addr", last_waddr, 16'h8003);

        // Reset mid-operation.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(BusWriteIo, '0, 8'(8'hA0 + i));
            step();
        end
        drive(BusReadIo, '0, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        run = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_val_in", core_val_in, 8'h00);
        drive(BusNone, '0, 8'h00);
        step();
        reset = 1'b0;
        run = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Idle after draining while halted.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(BusWriteIo, '0, 8'(8'hC0 + i));
            step();
        end
        drive(BusNone, '0, 8'h00);
        core_halted = 1'b1;
        out_ready   = 1'b1;
        #1;
        check("idle_0a", idle, 1'b0);
        step();
        check("idle_0b", idle, 1'b0);
        step();
        check("idle_1", idle, 1'b1);
        core_halted = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            run          = ($urandom_range(0, 7) != 0);
            core_bus_op  = BusOp'($urandom_range(0, 5));
            core_addr    = ADDR_WIDTH'($urandom_range(0, 31));
            core_val_out = 8'($urandom);
            in_valid     = $urandom_range(0, 1) == 1;
            in_data      = 8'($urandom);
            out_ready    = $urandom_range(0, 2) != 0;
            core_halted  = $urandom_range(0, 9) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bf_bus_unit.md
# bf_bus_unit

Bus back-end for the BF interpreter core. It takes the core's per-cycle bus request (`bus_op`, `addr`, `val_out`) and serves it:
- program and data reads/writes go to a synchronous RAM;
- IO reads come from a valid/ready byte-input channel;
- IO writes go into a small output FIFO drained over a valid/ready byte-output channel.

It returns read data on the core's `val_in` and stalls the core through its `enable` input whenever a request cannot complete in the current cycle.

## Interface
- `ADDR_WIDTH`, default 15: core address width; RAM address is `ADDR_WIDTH+1`.
- `BUS_WIDTH`, default 8: core data width (≥8).
- `OUT_DEPTH`, default 4: output FIFO depth, power of two, ≥2.
- `clock`  in  1  — clock; reset `reset`, asynchronous, active-high; clock `clock`.
- `reset`  in  1  — async active-high reset.
- `run`  in  1  — external run gate; 0 freezes the core.
- `core_bus_op`  in  BusOp  — request from the core.
- `core_addr`  in  ADDR_WIDTH  — request address.
- `core_val_out`  in  BUS_WIDTH  — write data from the core.
- `core_val_in`  out  BUS_WIDTH  — read data to the core.
- `core_enable`  out  1  — drives the core's `enable`.
- `core_halted`  in  1  — core halted flag.
- `mem_addr`  out  ADDR_WIDTH+1  — `{region, core_addr}`; region 0 = program, 1 = data.
- `mem_re`, `mem_we`  out  1 each  — RAM read/write strobes.
- `mem_wdata`  out  BUS_WIDTH  — RAM write data.
- `mem_rdata`  in  BUS_WIDTH  — RAM read data; 1-cycle latency, held while `mem_re`=0.
- `in_data`  in  8, `in_valid`  in  1, `in_ready`  out  1  — input byte channel.
- `out_data`  out  8, `out_valid`  out  1, `out_ready`  in  1  — output byte channel.
- `idle`  out  1  — `core_halted` and output FIFO empty.

## Operation
- **Commit.** A cycle with `core_enable`=1 commits the current `core_bus_op`. Only committed ops have side effects.
- **`core_enable`** is `run` AND NOT(op=BusReadIo AND NOT `in_valid`) AND NOT(op=BusWriteIo AND FIFO full).
- **BusReadProg / BusReadData**
  - `mem_re`=1 only on commit; `mem_addr` = {0 or 1, `core_addr`}.
  - Sets `rsrc`=Mem.
- **BusWriteData**
  - `mem_we`=1 only on commit; `mem_addr` = {1, `core_addr`}; `mem_wdata` = `core_val_out`.
- **BusReadIo**
  - `in_ready` = `run` AND op=BusReadIo.
  - On transfer (`in_valid` & `in_ready`), `in_data` is captured into `io_byte` and `rsrc` is set to Io.
- **BusWriteIo**
  - On commit, pushes `core_val_out[7:0]` into the FIFO.
  - A push while full is never attempted: the core stalls instead. A pop in the same cycle does not unblock a full FIFO (no pass-through).
- **BusNone / other**
  - No RAM strobe.
  - Sets `rsrc`=None on commit.
- **`core_val_in`** mux, selected by the `rsrc` register:
  - None → 0;
  - Mem → `mem_rdata`;
  - Io → zero-extended `io_byte`.
  - `rsrc` changes only on commit, so a core stalled in a decode state sees stable data.
- **Output FIFO**
  - `out_valid` = not empty; `out_data` = head.
  - Pop on `out_valid` & `out_ready`.
  - Simultaneous push and pop when non-full and non-empty leaves the count unchanged.
  - Pointers wrap modulo `OUT_DEPTH`; count has `$clog2(OUT_DEPTH)+1` bits.
- **Halt.** When `core_halted`, the core issues BusNone and the FIFO continues to drain. `idle` rises when the FIFO empties.

## Timing
- **Reset values:**
  - `rsrc`=None, `io_byte`=0, FIFO empty.
  - Hence `core_val_in`=0, `out_valid`=0, `out_data`=0.
  - `mem_re`=`mem_we`=0 (core in reset issues BusNone).
  - `in_ready` and `core_enable` follow their equations.
- **Reset mid-operation** discards FIFO contents and any captured byte. No RAM write occurs in the reset cycle.
- **Latencies:**
  - Memory read: commit at t, `core_val_in` valid at t+1.
  - IO read: transfer at t, data at t+1.
  - IO write: push at t, `out_valid` at t+1 (from empty).
- **Stalls** add whole cycles, with no limit. `in_ready` may drop without a transfer if `run` falls.

## Structure
- Shared package `bf_pkg` holds:
  - the `BusOp` enum (BusNone, BusReadProg, BusReadData, BusWriteData, BusReadIo, BusWriteIo), shared with the core;
  - the region constants RegionProg=0 and RegionData=1;
  - the `rsrc` enum (None, Mem, Io).
- Sub-module `bf_byte_fifo`:
  - parameter: depth;
  - ports: push/pop/full/empty/head.
- Top level holds the commit/stall logic, the strobes, `rsrc`/`io_byte`, and the `core_val_in` mux.

## Test plan
1. **Program read.** Reset, `run`=1, op=BusReadProg, addr 0x0005, RAM[0x0005]=0x2B → `mem_re`=1, `mem_addr`=0x0005 at t; `core_val_in`=0x2B at t+1; `core_val_in`=0 after a committed BusNone.
2. **IO read stall.** op=BusReadIo, `in_valid` low 3 cycles then high with 0x41 → `core_enable`=0 for 3 cycles, 1 on the 4th; exactly one transfer; `core_val_in`=0x41 next cycle.
3. **Output FIFO full.** `OUT_DEPTH`=4, `out_ready`=0, 5 consecutive BusWriteIo of 0x10..0x14 → 4 pushes, then `core_enable`=0. One-cycle `out_ready` pulse → pops 0x10. Next cycle 0x14 is pushed; drain order is 0x11..0x14.
4. **Run gating.** `run`=0 with op=BusWriteData, addr 0x0003, data 0x7F held 5 cycles → `mem_we`=0 throughout; `run`=1 → exactly one write to `mem_addr`=0x8003.
5. **Reset mid-operation.** FIFO holds 3 bytes, `rsrc`=Io; assert `reset` → `out_valid`=0 and `core_val_in`=0 immediately; no residual bytes after release.
6. **Idle.** `core_halted`=1, FIFO holds 2 bytes, `out_ready`=1 → `idle`=0 for 2 cycles, then 1.
